array_rmw_mp: RTL and testbench
===============================

Name: array_rmw_mp

Overview:
- Parametrised successor to the single-port array memory used by generated array primitives.
- Serves N_CH independent client channels, each with its own valid/ready request and response handshakes, behind a round-robin arbiter.
- Executes READ, WRITE, ADD and SWAP on a synchronous RAM. ADD and SWAP are atomic read-modify-write operations.
- Lets multiple generated instances (e.g. add-at-index kernels) share one array without external locking.

Parameters:
- N_CH, 2, number of client channels (1..8).
- addrN, 8, address width per channel.
- intN, 8, data width.
- DEPTH, 256, number of words; must be <= 2^addrN.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  N_CH  per-channel request valid.
- req_ready  out  N_CH  per-channel request accepted this cycle.
- req_op  in  2*N_CH  per-channel op: 0 READ, 1 WRITE, 2 ADD, 3 SWAP.
- req_addr  in  addrN*N_CH  per-channel word address; channel i occupies slice [i*addrN +: addrN].
- req_data  in  intN*N_CH  per-channel operand, sliced the same way.
- rsp_valid  out  N_CH  per-channel response valid.
- rsp_ready  in  N_CH  per-channel response consumed.
- rsp_data  out  intN  response data, shared by all channels; meaningful only for the channel whose rsp_valid is high.
- rsp_err  out  1  response is an out-of-range error.
- busy  out  1  an operation is in flight (state != IDLE).

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0, state=IDLE, rr_ptr=0.
- RAM contents are not reset.
- Exactly one operation is in flight at a time. At most one rsp_valid bit is high.
- Arbiter (IDLE only):
  - grant = first i with req_valid[i], scanning from rr_ptr upward modulo N_CH.
  - req_ready[grant]=1 combinationally; all other req_ready bits are 0.
  - req_ready is 0 in every state other than IDLE.
- Accept: a transfer occurs when req_valid[i] & req_ready[i] at a rising edge (cycle t).
  - On accept, latch op, addr, data and channel id, and set rr_ptr = (grant+1) mod N_CH.
- FSM: IDLE -> RD -> (WR) -> RESP -> IDLE.
  - RD: RAM read issued. Data is registered and available at the end of RD.
  - WR (ADD/SWAP only): writes the new value.
    - ADD writes (old+data) mod 2^intN; carry is discarded.
    - SWAP writes data.
  - WRITE op: the write is performed in RD and the FSM goes straight to RESP; rsp_data = written data.
  - RESP: rsp_valid[ch]=1 and held with data stable until rsp_ready[ch]. Then return to IDLE. The new arbitration takes effect in that same IDLE cycle.
- Response data:
  - READ: old value.
  - ADD: new value (sum).
  - SWAP: old value.
  - WRITE: echo of the written data.
- Latency, accept at t to rsp_valid first high:
  - READ and WRITE: t+2.
  - ADD and SWAP: t+3.
  - Out-of-range: t+1.
- Out-of-range (addr >= DEPTH): no RAM access; the FSM goes IDLE -> RESP directly with rsp_err=1 and rsp_data=0.
- Throughput: one op per 3 cycles minimum (READ with rsp_ready held high).
- Back-to-back operations on the same address see the prior op's write, since only one op is in flight.
- rsp_ready on a channel without rsp_valid is ignored. req_valid may drop without acceptance; no state change results.
- Reset mid-operation: the FSM returns to IDLE and the pending response is discarded.
  - ADD/SWAP reset before the WR edge leaves RAM unchanged (atomic).
  - A WRITE already committed in RD remains.
- N_CH=1: the arbiter degenerates to always granting channel 0.

Test Plan:
- Single channel: WRITE addr=3 data=42, then READ addr=3 -> rsp_data=42 at t+2 for the read, rsp_err=0.
- ADD wrap: mem[5]=250, ADD addr=5 data=10 -> rsp_data=4 at t+3; a subsequent READ addr=5 returns 4.
- Contention: ch0 and ch1 both assert ADD addr=7 data=1 continuously for 4 ops each, starting from mem[7]=0 -> grants alternate 0,1,0,1,...; the final READ returns 8; no response is lost.
- Backpressure: hold rsp_ready=0 for 5 cycles on a READ -> rsp_valid and rsp_data stay stable, all req_ready=0, busy=1; completes one cycle after rsp_ready rises.
- Out-of-range: DEPTH=16, READ addr=20 -> rsp_valid at t+1, rsp_err=1, rsp_data=0; RAM unchanged.
- Reset mid-op: mem[9]=1, accept SWAP addr=9 data=77, assert rst during RD -> all outputs return to reset values; a later READ addr=9 returns 1.

Source files
------------

// File: rtl/array_rmw_mp.sv
// Multi-channel word array with round-robin arbitration and atomic ADD/SWAP.
// Only one operation is in flight at a time, so read-modify-write needs no external locking.
module array_rmw_mp #(
   parameter int N_CH  = 2,
   parameter int addrN = 8,
   parameter int intN  = 8,
   parameter int DEPTH = 256
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_CH-1:0]       req_valid,
   output logic [N_CH-1:0]       req_ready,
   input  logic [2*N_CH-1:0]     req_op,
   input  logic [addrN*N_CH-1:0] req_addr,
   input  logic [intN*N_CH-1:0]  req_data,
   output logic [N_CH-1:0]       rsp_valid,
   input  logic [N_CH-1:0]       rsp_ready,
   output logic [intN-1:0]       rsp_data,
   output logic                  rsp_err,
   output logic                  busy
);

   localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [addrN:0] DEPTH_W = (addrN + 1)'(DEPTH);

   typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_ADD, OP_SWAP} op_t;
   typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

   state_t            state, state_nx;
   op_t               op_q;
   logic [addrN-1:0]  addr_q;
   logic [intN-1:0]   data_q;
   logic [CW-1:0]     ch_q;
   logic [CW-1:0]     rr_ptr;
   logic [CW-1:0]     grant;
   logic              grant_found;
   int                idx;
   logic              accept;
   logic [1:0]        g_op;
   logic [addrN-1:0]  g_addr;
   logic [intN-1:0]   g_data;
   logic              g_oor;
   logic [AW-1:0]     mem_idx;
   logic              mem_we;
   logic [intN-1:0]   mem_wdata;
   logic [intN-1:0]   sum;
   logic              unused_addr_hi;
   logic [intN-1:0]   mem [DEPTH];

   // Round-robin scan starting at rr_ptr; first requesting channel wins.
   always_comb begin
      grant_found = 1'b0;
      grant       = '0;
      idx         = 0;
      for (int k = 0; k < N_CH; k++) begin
         idx = (int'(rr_ptr) + k) % N_CH;
         if (!grant_found && req_valid[idx]) begin
            grant_found = 1'b1;
            grant       = CW'(idx);
         end
      end
   end

   assign g_op    = req_op[2*int'(grant) +: 2];
   assign g_addr  = req_addr[addrN*int'(grant) +: addrN];
   assign g_data  = req_data[intN*int'(grant) +: intN];
   assign g_oor   = {1'b0, g_addr} >= DEPTH_W;
   assign accept  = (state == IDLE) && grant_found && !rst;

   assign mem_idx        = addr_q[AW-1:0];
   assign unused_addr_hi = ^addr_q;
   assign sum            = rsp_data + data_q;
   assign busy           = (state != IDLE);

   always_comb begin
      req_ready = '0;
      rsp_valid = '0;
      if (accept)
         req_ready[grant] = 1'b1;
      if (state == RESP)
         rsp_valid[ch_q] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   // Out-of-range requests bypass the RAM; WRITE commits in RD and skips WR.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (accept) state_nx = g_oor ? RESP : RD;
         RD:   state_nx = (op_q == OP_READ || op_q == OP_WRITE) ? RESP : WR;
         WR:   state_nx = RESP;
         RESP: if (rsp_ready[ch_q]) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // rsp_data doubles as the old-value register between RD and WR.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q     <= OP_READ;
         addr_q   <= '0;
         data_q   <= '0;
         ch_q     <= '0;
         rr_ptr   <= '0;
         rsp_data <= '0;
         rsp_err  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  op_q     <= op_t'(g_op);
                  addr_q   <= g_addr;
                  data_q   <= g_data;
                  ch_q     <= grant;
                  rr_ptr   <= (grant == CW'(N_CH - 1)) ? '0 : grant + 1'b1;
                  rsp_err  <= g_oor;
                  rsp_data <= '0;
               end
            end
            RD:   rsp_data <= (op_q == OP_WRITE) ? data_q : mem[mem_idx];
            WR:   if (op_q == OP_ADD) rsp_data <= sum;
            RESP: if (rsp_ready[ch_q]) rsp_err <= 1'b0;
            default: ;
         endcase
      end
   end

   always_comb begin
      mem_we    = 1'b0;
      mem_wdata = data_q;
      if (state == RD && op_q == OP_WRITE)
         mem_we = 1'b1;
      if (state == WR) begin
         mem_we    = 1'b1;
         mem_wdata = (op_q == OP_ADD) ? sum : data_q;
      end
   end

   // Array contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (mem_we)
         mem[mem_idx] <= mem_wdata;
   end

endmodule

// File: tb/tb_array_rmw_mp.sv
// Directed bench for array_rmw_mp: vector table of single ops plus
// hand-written backpressure, contention and reset-mid-op sequences.
module tb_array_rmw_mp;

   localparam int N_CH  = 2;
   localparam int AN    = 8;
   localparam int DN    = 8;
   localparam int DEPTH = 16;

   localparam logic [1:0] R = 2'd0;
   localparam logic [1:0] W = 2'd1;
   localparam logic [1:0] A = 2'd2;
   localparam logic [1:0] S = 2'd3;

   logic              clk = 1'b0;
   logic              rst;
   logic [N_CH-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
   logic [2*N_CH-1:0] req_op;
   logic [AN*N_CH-1:0] req_addr;
   logic [DN*N_CH-1:0] req_data;
   logic [DN-1:0]     rsp_data;
   logic              rsp_err, busy;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      string      name;
      int         ch;
      logic [1:0] op;
      logic [7:0] addr;
      logic [7:0] data;
      logic [7:0] exp_data;
      logic       exp_err;
      int         exp_lat;
   } vec_t;

   vec_t vecs[$];

   array_rmw_mp #(.N_CH(N_CH), .addrN(AN), .intN(DN), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_addr(req_addr), .req_data(req_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic timeoutFail(input string name);
      checks++;
      failures++;
      $display("[TB] FAIL %s: timed out waiting for DUT", name);
   endtask

   task automatic waitReady(input int ch, output bit ok);
      int n = 0;
      #1;
      while (!req_ready[ch] && n < 20) begin
         @(posedge clk); #1; n++;
      end
      ok = req_ready[ch];
   endtask

   // Issues one request on a channel and returns the response and its latency.
   task automatic applyStimulus(input int ch, input logic [1:0] op, input logic [7:0] addr,
                                input logic [7:0] data, output logic [7:0] d,
                                output logic e, output int lat);
      bit ok;
      d = '0; e = 1'b0; lat = 0;
      req_valid[ch] = 1'b1;
      req_op[ch*2 +: 2]   = op;
      req_addr[ch*AN +: AN] = addr;
      req_data[ch*DN +: DN] = data;
      waitReady(ch, ok);
      if (!ok) begin
         timeoutFail("accept");
         req_valid[ch] = 1'b0;
         return;
      end
      @(posedge clk); #1;
      req_valid[ch] = 1'b0;
      lat = 1;
      while (!rsp_valid[ch] && lat < 20) begin
         @(posedge clk); #1; lat++;
      end
      if (!rsp_valid[ch]) begin
         timeoutFail("response");
         return;
      end
      d = rsp_data;
      e = rsp_err;
      rsp_ready[ch] = 1'b1;
      @(posedge clk); #1;
      rsp_ready[ch] = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      logic [7:0] d;
      logic       e;
      int         lat;
      bit         ok;
      int         cnt [2];
      bit         drop [2];
      int         resp_cnt, last_grant, cyc;

      rst = 1'b1; req_valid = '0; rsp_ready = '0;
      req_op = '0; req_addr = '0; req_data = '0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_req_ready", req_ready, 0);
      checkOutput("reset_rsp_valid", rsp_valid, 0);
      checkOutput("reset_rsp_data",  rsp_data, 0);
      checkOutput("reset_rsp_err",   rsp_err, 0);
      checkOutput("reset_busy",      busy, 0);
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;

      vecs.push_back('{"w3",      0, W,  3,  42,  42, 0, 2});
      vecs.push_back('{"r3",      0, R,  3,   0,  42, 0, 2});
      vecs.push_back('{"w5",      1, W,  5, 250, 250, 0, 2});
      vecs.push_back('{"add5",    1, A,  5,  10,   4, 0, 3});
      vecs.push_back('{"r5",      0, R,  5,   0,   4, 0, 2});
      vecs.push_back('{"swap5",   0, S,  5,  99,   4, 0, 3});
      vecs.push_back('{"r5b",     1, R,  5,   0,  99, 0, 2});
      vecs.push_back('{"w0",      0, W,  0,  11,  11, 0, 2});
      vecs.push_back('{"w16oor",  1, W, 16,   7,   0, 1, 1});
      vecs.push_back('{"r0",      0, R,  0,   0,  11, 0, 2});
      vecs.push_back('{"r20oor",  0, R, 20,   0,   0, 1, 1});
      vecs.push_back('{"w15",     1, W, 15, 200, 200, 0, 2});
      vecs.push_back('{"add15",   0, A, 15,  55, 255, 0, 3});
      vecs.push_back('{"add15w",  1, A, 15,   1,   0, 0, 3});
      vecs.push_back('{"s31oor",  1, S, 31,   5,   0, 1, 1});
      vecs.push_back('{"r15",     0, R, 15,   0,   0, 0, 2});

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].ch, vecs[i].op, vecs[i].addr, vecs[i].data, d, e, lat);
         checkOutput($sformatf("%s_data", vecs[i].name), d, vecs[i].exp_data);
         checkOutput($sformatf("%s_err",  vecs[i].name), e, vecs[i].exp_err);
         checkOutput($sformatf("%s_lat",  vecs[i].name), lat, vecs[i].exp_lat);
         checkOutput($sformatf("%s_idle", vecs[i].name), busy, 0);
      end

      // Backpressure: ch0 READ held 5 cycles while ch1 waits with its own rsp_ready high.
      applyStimulus(0, W, 2, 33, d, e, lat);
      checkOutput("bp_setup", d, 33);
      req_valid[0] = 1'b1; req_op[1:0] = R; req_addr[7:0] = 8'd2;
      waitReady(0, ok);
      if (!ok) timeoutFail("bp_accept");
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      req_valid[1] = 1'b1; req_op[3:2] = R; req_addr[15:8] = 8'd2;
      rsp_ready[1] = 1'b1;
      @(posedge clk); #1;
      for (int c = 0; c < 5; c++) begin
         checkOutput("bp_rsp_valid", rsp_valid, 2'b01);
         checkOutput("bp_rsp_data",  rsp_data, 33);
         checkOutput("bp_req_ready", req_ready, 0);
         checkOutput("bp_busy",      busy, 1);
         @(posedge clk); #1;
      end
      rsp_ready[0] = 1'b1;
      @(posedge clk); #1;
      rsp_ready[0] = 1'b0;
      checkOutput("bp_done_valid", rsp_valid, 0);
      checkOutput("bp_done_busy",  busy, 0);
      checkOutput("bp_next_grant", req_ready, 2'b10);
      @(posedge clk); #1;
      req_valid[1] = 1'b0;
      cyc = 0;
      while (!rsp_valid[1] && cyc < 20) begin
         @(posedge clk); #1; cyc++;
      end
      checkOutput("bp_ch1_valid", rsp_valid, 2'b10);
      checkOutput("bp_ch1_data",  rsp_data, 33);
      @(posedge clk); #1;
      rsp_ready[1] = 1'b0;

      // Contention: both channels ADD 1 to address 7 four times each.
      applyStimulus(1, W, 7, 0, d, e, lat);
      checkOutput("cont_setup", d, 0);
      req_op = {A, A};
      req_addr = {8'd7, 8'd7};
      req_data = {8'd1, 8'd1};
      req_valid = 2'b11;
      rsp_ready = 2'b11;
      cnt[0] = 0; cnt[1] = 0; drop[0] = 0; drop[1] = 0;
      resp_cnt = 0; last_grant = -1; cyc = 0;
      #1;
      while (resp_cnt < 8 && cyc < 100) begin
         if (rsp_valid != 0) begin
            checkOutput("cont_onehot", $countones(rsp_valid), 1);
            resp_cnt++;
            checkOutput("cont_rsp_data", rsp_data, resp_cnt);
         end
         for (int i = 0; i < 2; i++) begin
            if (req_valid[i] && req_ready[i]) begin
               if (last_grant >= 0)
                  checkOutput("cont_alternate", i, 1 - last_grant);
               last_grant = i;
               cnt[i]++;
               if (cnt[i] == 4) drop[i] = 1;
            end
         end
         @(posedge clk); #1;
         for (int i = 0; i < 2; i++) begin
            if (drop[i]) begin
               req_valid[i] = 1'b0;
               drop[i] = 0;
            end
         end
         #1;
         cyc++;
      end
      rsp_ready = '0;
      req_valid = '0;
      checkOutput("cont_responses", resp_cnt, 8);
      checkOutput("cont_ch0_grants", cnt[0], 4);
      checkOutput("cont_ch1_grants", cnt[1], 4);
      @(posedge clk); #1;
      applyStimulus(1, R, 7, 0, d, e, lat);
      checkOutput("cont_final", d, 8);

      // Reset during RD of a SWAP must leave the word untouched.
      applyStimulus(0, W, 9, 1, d, e, lat);
      checkOutput("rst_setup", d, 1);
      req_valid[0] = 1'b1; req_op[1:0] = S; req_addr[7:0] = 8'd9; req_data[7:0] = 8'd77;
      waitReady(0, ok);
      if (!ok) timeoutFail("rst_accept");
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      checkOutput("rst_busy_before", busy, 1);
      rst = 1'b1;
      #1;
      checkOutput("rst_req_ready", req_ready, 0);
      checkOutput("rst_rsp_valid", rsp_valid, 0);
      checkOutput("rst_rsp_data",  rsp_data, 0);
      checkOutput("rst_rsp_err",   rsp_err, 0);
      checkOutput("rst_busy",      busy, 0);
      @(posedge clk);
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
      req_op = {R, R};
      req_addr = {8'd9, 8'd9};
      req_valid = 2'b11;
      #1;
      checkOutput("rst_rr_ptr", req_ready, 2'b01);
      req_valid = '0;
      applyStimulus(0, R, 9, 0, d, e, lat);
      checkOutput("rst_swap_atomic", d, 1);

      // A WRITE committed in RD survives a reset during RESP.
      req_valid[1] = 1'b1; req_op[3:2] = W; req_addr[15:8] = 8'd10; req_data[15:8] = 8'd5;
      waitReady(1, ok);
      if (!ok) timeoutFail("rstw_accept");
      @(posedge clk); #1;
      req_valid[1] = 1'b0;
      @(posedge clk); #1;
      checkOutput("rstw_rsp_valid", rsp_valid, 2'b10);
      rst = 1'b1;
      #1;
      checkOutput("rstw_cleared", rsp_valid, 0);
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
      applyStimulus(0, R, 10, 0, d, e, lat);
      checkOutput("rstw_kept", d, 5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
